// File: rtl/b2_phase_sequencer_pkg.sv
// Shared types and constants for the Block2 phase sequencer.
package b2_seq_pkg;

    // Sequencer states, in the order a frame walks through them
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_WEIGHT = 3'd2,
        ST_SLIDE  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } seq_state_t;

    // Error codes reported on err_code while err is high
    localparam logic [1:0] ERR_OVERRUN = 2'd0;
    localparam logic [1:0] ERR_FILL    = 2'd1;
    localparam logic [1:0] ERR_WEIGHT  = 2'd2;
    localparam logic [1:0] ERR_SLIDE   = 2'd3;

    // Phase counter width: wide enough for both the watchdog limit and the
    // drain length, since one counter serves both
    function automatic int cnt_w(input int timeout, input int drain_cyc);
        int biggest;
        biggest = (timeout > drain_cyc) ? timeout : drain_cyc;
        return (biggest <= 2) ? 1 : $clog2(biggest);
    endfunction

endpackage

// File: rtl/b2_phase_sequencer_if.sv
// Input-buffer port bundle: the two requesters (fill controller and
// sliding-window unit) and the arbitrated port driven to the buffer banks.
interface b2_phase_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_wea;
    logic              fill_ena;

    logic [ADDR_W-1:0] swu_addr;
    logic              swu_wea;
    logic              swu_ena;

    logic [ADDR_W-1:0] ib_addr;
    logic              ib_wea;
    logic              ib_ena;

    // Sequencer side: consumes both requester ports, drives the buffer port
    modport master (
        input  fill_addr, fill_wea, fill_ena,
        input  swu_addr,  swu_wea,  swu_ena,
        output ib_addr,   ib_wea,   ib_ena
    );

    // Environment side: requesters drive, buffer banks observe
    modport slave (
        output fill_addr, fill_wea, fill_ena,
        output swu_addr,  swu_wea,  swu_ena,
        input  ib_addr,   ib_wea,   ib_ena
    );
endinterface

// File: rtl/b2_phase_sequencer_timer.sv
// Shared phase counter. Cleared whenever the sequencer changes state, it
// counts cycles spent in the current phase and flags both the watchdog
// limit and the end of the drain window.
module b2_phase_timer #(
    parameter int TIMEOUT   = 1024,
    parameter int DRAIN_CYC = 4,
    parameter int CNT_W     = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic timeout,
    output logic drain_end
);

    logic [CNT_W-1:0] count;

    // Restart on phase entry, otherwise count while a timed phase is active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

    assign timeout   = (count == CNT_W'(TIMEOUT - 1));
    assign drain_end = (count == CNT_W'(DRAIN_CYC - 1));

endmodule

// File: rtl/b2_phase_sequencer.sv
// Block2 phase sequencer: walks each frame through fill, weight transfer,
// sliding-window compute and pipeline drain, arbitrates the input-buffer
// port, guards each phase with a watchdog and queues one pending frame.
module b2_phase_sequencer
    import b2_seq_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int TIMEOUT   = 1024,
    parameter int DRAIN_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bin_val,
    input  logic                  fill_done,
    input  logic                  wt_done,
    input  logic                  slide_done,
    b2_phase_sequencer_if.master  buf_if,
    output logic                  fill_en,
    output logic                  wt_en,
    output logic                  swu_en,
    output logic                  pe_en,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            frame_cnt,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int CNT_W = cnt_w(TIMEOUT, DRAIN_CYC);

    seq_state_t        state;
    seq_state_t        state_next;
    logic              bin_val_d;
    logic              rise;
    logic              pending;
    logic              phase_active;
    logic              timeout;
    logic              drain_end;
    logic [1:0]        fault_code;
    logic              pending_set;
    logic              overrun_drop;
    logic [ADDR_W-1:0] mux_addr;
    logic              mux_wea;
    logic              mux_ena;

    assign rise         = bin_val & ~bin_val_d;
    assign phase_active = (state == ST_FILL)  || (state == ST_WEIGHT) ||
                          (state == ST_SLIDE) || (state == ST_DRAIN);

    b2_phase_timer #(
        .TIMEOUT   (TIMEOUT),
        .DRAIN_CYC (DRAIN_CYC),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state_next != state),
        .run       (phase_active),
        .timeout   (timeout),
        .drain_end (drain_end)
    );

    // State register and the delayed copy of bin_val for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bin_val_d <= 1'b0;
        end else begin
            state     <= state_next;
            bin_val_d <= bin_val;
        end
    end

    // Next-state logic; a done pulse beats a same-cycle watchdog expiry
    always_comb begin
        state_next = state;
        fault_code = ERR_OVERRUN;
        case (state)
            ST_IDLE: begin
                if (rise) state_next = ST_FILL;
            end
            ST_FILL: begin
                if (fill_done) begin
                    state_next = ST_WEIGHT;
                end else if (timeout) begin
                    state_next = ST_ERR;
                    fault_code = ERR_FILL;
                end
            end
            ST_WEIGHT: begin
                if (wt_done) begin
                    state_next = ST_SLIDE;
                end else if (timeout) begin
                    state_next = ST_ERR;
                    fault_code = ERR_WEIGHT;
                end
            end
            ST_SLIDE: begin
                if (slide_done) begin
                    state_next = ST_DRAIN;
                end else if (timeout) begin
                    state_next = ST_ERR;
                    fault_code = ERR_SLIDE;
                end
            end
            ST_DRAIN: begin
                if (drain_end) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = (pending || rise) ? ST_FILL : ST_IDLE;
            end
            ST_ERR: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Classify a mid-frame request: queue it, or drop it as an overrun
    always_comb begin
        pending_set  = 1'b0;
        overrun_drop = 1'b0;
        if (rise && phase_active) begin
            if (!pending) begin
                pending_set = 1'b1;
            end else if (state_next != ST_ERR) begin
                overrun_drop = 1'b1;
            end
        end
    end

    // One-deep pending-frame slot, consumed by DONE and flushed by ERR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if ((state == ST_DONE) || (state == ST_ERR) || (state_next == ST_ERR)) begin
            pending <= 1'b0;
        end else if (pending_set) begin
            pending <= 1'b1;
        end
    end

    // Registered frame and error status, aligned with the DONE/ERR cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            err        <= 1'b0;
            err_code   <= ERR_OVERRUN;
        end else begin
            frame_done <= (state_next == ST_DONE);
            if (state_next == ST_DONE) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            err <= (state_next == ST_ERR) || overrun_drop;
            if (state_next == ST_ERR) begin
                err_code <= fault_code;
            end else if (overrun_drop) begin
                err_code <= ERR_OVERRUN;
            end
        end
    end

    // Moore decode of the phase enables
    always_comb begin
        fill_en = 1'b0;
        wt_en   = 1'b0;
        swu_en  = 1'b0;
        pe_en   = 1'b0;
        busy    = (state != ST_IDLE);
        case (state)
            ST_FILL:   fill_en = 1'b1;
            ST_WEIGHT: wt_en   = 1'b1;
            ST_SLIDE: begin
                swu_en = 1'b1;
                pe_en  = 1'b1;
            end
            ST_DRAIN:  pe_en   = 1'b1;
            default: begin
                fill_en = 1'b0;
            end
        endcase
    end

    // Buffer-port arbitration: the owner of the current phase gets the port
    always_comb begin
        mux_addr = '0;
        mux_wea  = 1'b0;
        mux_ena  = 1'b0;
        case (state)
            ST_FILL: begin
                mux_addr = buf_if.fill_addr;
                mux_wea  = buf_if.fill_wea;
                mux_ena  = buf_if.fill_ena;
            end
            ST_SLIDE: begin
                mux_addr = buf_if.swu_addr;
                mux_wea  = buf_if.swu_wea;
                mux_ena  = buf_if.swu_ena;
            end
            default: begin
                mux_addr = '0;
            end
        endcase
    end

    assign buf_if.ib_addr = mux_addr;
    assign buf_if.ib_wea  = mux_wea;
    assign buf_if.ib_ena  = mux_ena;

endmodule

// File: tb/tb_b2_phase_sequencer.sv
// Directed bench for the Block2 phase sequencer (TIMEOUT=16, DRAIN_CYC=4).
module tb_b2_phase_sequencer;

    logic       clk;
    logic       rst_n;
    logic       bin_val;
    logic       fill_done;
    logic       wt_done;
    logic       slide_done;
    logic       fill_en;
    logic       wt_en;
    logic       swu_en;
    logic       pe_en;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_cnt;
    logic       err;
    logic [1:0] err_code;
    logic [3:0] en_vec;
    logic [6:0] ib_vec;

    int         vectors;
    int         miscompares;
    logic [7:0] exp_frames;

    b2_phase_sequencer_if #(.ADDR_W(5)) buf_if ();

    b2_phase_sequencer #(
        .ADDR_W    (5),
        .TIMEOUT   (16),
        .DRAIN_CYC (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bin_val    (bin_val),
        .fill_done  (fill_done),
        .wt_done    (wt_done),
        .slide_done (slide_done),
        .buf_if     (buf_if.master),
        .fill_en    (fill_en),
        .wt_en      (wt_en),
        .swu_en     (swu_en),
        .pe_en      (pe_en),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .err        (err),
        .err_code   (err_code)
    );

    assign en_vec = {fill_en, wt_en, swu_en, pe_en};
    assign ib_vec = {buf_if.ib_addr, buf_if.ib_wea, buf_if.ib_ena};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 fill_done, 1 wt_done, 2 slide_done
    task automatic pulse_done(input int which);
        case (which)
            0: fill_done  = 1'b1;
            1: wt_done    = 1'b1;
            default: slide_done = 1'b1;
        endcase
        tick();
        fill_done  = 1'b0;
        wt_done    = 1'b0;
        slide_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bin_val    = 1'b0;
        fill_done  = 1'b0;
        wt_done    = 1'b0;
        slide_done = 1'b0;
        buf_if.fill_addr = 5'd7;
        buf_if.fill_wea  = 1'b1;
        buf_if.fill_ena  = 1'b1;
        buf_if.swu_addr  = 5'd12;
        buf_if.swu_wea   = 1'b1;
        buf_if.swu_ena   = 1'b1;
        #12;
        vectors++;
        if (en_vec !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_enables: got %b expected 0000", en_vec);
        end
        vectors++;
        if ({busy, frame_done, err} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_status: busy/frame_done/err got %b expected 000", {busy, frame_done, err});
        end
        vectors++;
        if ({err_code, frame_cnt} !== 10'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_counts: err_code %0d frame_cnt %0d expected 0 0", err_code, frame_cnt);
        end
        vectors++;
        if (ib_vec !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_ib_port: got %h expected 0", ib_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_frames = 8'd0;
        tick();
    endtask

    task automatic test_stray_dones();
        pulse_done(0);
        pulse_done(1);
        pulse_done(2);
        vectors++;
        if ({busy, en_vec} !== 5'b0_0000) begin
            miscompares++;
            $display("[TB] FAIL stray_idle: busy/en got %b expected 00000", {busy, en_vec});
        end
        bin_val = 1'b1;
        tick();
        pulse_done(1);
        vectors++;
        if (en_vec !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL stray_wt_in_fill: got %b expected 1000", en_vec);
        end
        pulse_done(0);
        pulse_done(0);
        vectors++;
        if (en_vec !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL stray_fill_in_weight: got %b expected 0100", en_vec);
        end
        pulse_done(2);
        vectors++;
        if ({en_vec, err} !== 5'b0100_0) begin
            miscompares++;
            $display("[TB] FAIL stray_slide_in_weight: got %b expected 01000", {en_vec, err});
        end
        rst_n   = 1'b0;
        bin_val = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_frames = 8'd0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stray_abort_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_nominal();
        bin_val = 1'b0;
        tick();
        bin_val = 1'b1;
        tick();
        vectors++;
        if ({busy, en_vec, ib_vec} !== {1'b1, 4'b1000, 5'd7, 1'b1, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL nominal_fill_entry: busy/en/ib got %b expected %b",
                     {busy, en_vec, ib_vec}, {1'b1, 4'b1000, 5'd7, 2'b11});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({en_vec, err} !== 5'b1000_0) begin
                miscompares++;
                $display("[TB] FAIL nominal_fill_hold[%0d]: got %b expected 10000", i, {en_vec, err});
            end
        end
        pulse_done(0);
        vectors++;
        if ({en_vec, ib_vec} !== {4'b0100, 7'd0}) begin
            miscompares++;
            $display("[TB] FAIL nominal_weight_entry: en/ib got %b expected %b", {en_vec, ib_vec}, {4'b0100, 7'd0});
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({en_vec, err} !== 5'b0100_0) begin
                miscompares++;
                $display("[TB] FAIL nominal_weight_hold[%0d]: got %b expected 01000", i, {en_vec, err});
            end
        end
        pulse_done(1);
        vectors++;
        if ({en_vec, ib_vec} !== {4'b0011, 5'd12, 1'b1, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL nominal_slide_entry: en/ib got %b expected %b", {en_vec, ib_vec}, {4'b0011, 5'd12, 2'b11});
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            vectors++;
            if ({en_vec, err} !== 5'b0011_0) begin
                miscompares++;
                $display("[TB] FAIL nominal_slide_hold[%0d]: got %b expected 00110", i, {en_vec, err});
            end
        end
        pulse_done(2);
        vectors++;
        if ({en_vec, ib_vec, frame_done} !== {4'b0001, 7'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL nominal_drain_entry: en/ib/fd got %b expected %b", {en_vec, ib_vec, frame_done}, {4'b0001, 8'd0});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({en_vec, frame_done, err} !== 6'b0001_00) begin
                miscompares++;
                $display("[TB] FAIL nominal_drain_hold[%0d]: got %b expected 000100", i, {en_vec, frame_done, err});
            end
        end
        tick();
        exp_frames = exp_frames + 8'd1;
        vectors++;
        if ({frame_done, busy, en_vec, ib_vec} !== {1'b1, 1'b1, 4'b0000, 7'd0}) begin
            miscompares++;
            $display("[TB] FAIL nominal_done: fd/busy/en/ib got %b expected %b",
                     {frame_done, busy, en_vec, ib_vec}, {2'b11, 11'd0});
        end
        vectors++;
        if (frame_cnt !== exp_frames) begin
            miscompares++;
            $display("[TB] FAIL nominal_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames);
        end
        tick();
        vectors++;
        if ({busy, frame_done, err} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL nominal_back_idle: busy/fd/err got %b expected 000", {busy, frame_done, err});
        end
        bin_val = 1'b0;
    endtask

    task automatic test_watchdog();
        bin_val = 1'b0;
        tick();
        bin_val = 1'b1;
        tick();
        pulse_done(0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            vectors++;
            if ({en_vec, err} !== 5'b0100_0) begin
                miscompares++;
                $display("[TB] FAIL watchdog_weight_hold[%0d]: got %b expected 01000", i, {en_vec, err});
            end
        end
        tick();
        vectors++;
        if ({err, err_code, busy, en_vec} !== {1'b1, 2'd2, 1'b1, 4'b0000}) begin
            miscompares++;
            $display("[TB] FAIL watchdog_err: err/code/busy/en got %b expected %b",
                     {err, err_code, busy, en_vec}, {1'b1, 2'd2, 1'b1, 4'b0000});
        end
        tick();
        vectors++;
        if ({err, busy, frame_done} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL watchdog_recover: err/busy/fd got %b expected 000", {err, busy, frame_done});
        end
        vectors++;
        if (frame_cnt !== exp_frames) begin
            miscompares++;
            $display("[TB] FAIL watchdog_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames);
        end
        bin_val = 1'b0;
    endtask

    task automatic test_timeout_tie();
        bin_val = 1'b0;
        tick();
        bin_val = 1'b1;
        tick();
        pulse_done(0);
        for (int i = 1; i <= 15; i++) begin
            tick();
        end
        vectors++;
        if ({en_vec, err} !== 5'b0100_0) begin
            miscompares++;
            $display("[TB] FAIL tie_last_weight_cycle: got %b expected 01000", {en_vec, err});
        end
        pulse_done(1);
        vectors++;
        if ({en_vec, err, busy} !== 6'b0011_01) begin
            miscompares++;
            $display("[TB] FAIL tie_done_wins: en/err/busy got %b expected 001101", {en_vec, err, busy});
        end
        pulse_done(2);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        exp_frames = exp_frames + 8'd1;
        vectors++;
        if ({frame_done, frame_cnt} !== {1'b1, exp_frames}) begin
            miscompares++;
            $display("[TB] FAIL tie_frame_done: fd %b cnt %0d expected 1 %0d", frame_done, frame_cnt, exp_frames);
        end
        tick();
        bin_val = 1'b0;
    endtask

    task automatic test_back_to_back();
        bin_val = 1'b0;
        tick();
        bin_val = 1'b1;
        tick();
        pulse_done(0);
        pulse_done(1);
        bin_val = 1'b0;
        tick();
        bin_val = 1'b1;
        tick();
        vectors++;
        if ({en_vec, err} !== 5'b0011_0) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_rise_queued: got %b expected 00110", {en_vec, err});
        end
        bin_val = 1'b0;
        tick();
        bin_val = 1'b1;
        tick();
        vectors++;
        if ({err, err_code, en_vec} !== {1'b1, 2'd0, 4'b0011}) begin
            miscompares++;
            $display("[TB] FAIL b2b_overrun: err/code/en got %b expected %b", {err, err_code, en_vec}, {1'b1, 2'd0, 4'b0011});
        end
        tick();
        vectors++;
        if ({err, en_vec} !== 5'b0_0011) begin
            miscompares++;
            $display("[TB] FAIL b2b_overrun_clears: err/en got %b expected 00011", {err, en_vec});
        end
        pulse_done(2);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        exp_frames = exp_frames + 8'd1;
        vectors++;
        if ({frame_done, frame_cnt} !== {1'b1, exp_frames}) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_done: fd %b cnt %0d expected 1 %0d", frame_done, frame_cnt, exp_frames);
        end
        tick();
        vectors++;
        if ({busy, en_vec, frame_done} !== {1'b1, 4'b1000, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL b2b_refill: busy/en/fd got %b expected 110000", {busy, en_vec, frame_done});
        end
        pulse_done(0);
        pulse_done(1);
        pulse_done(2);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        exp_frames = exp_frames + 8'd1;
        vectors++;
        if ({frame_done, frame_cnt} !== {1'b1, exp_frames}) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_done: fd %b cnt %0d expected 1 %0d", frame_done, frame_cnt, exp_frames);
        end
        tick();
        vectors++;
        if ({busy, en_vec} !== 5'b0_0000) begin
            miscompares++;
            $display("[TB] FAIL b2b_pending_cleared: busy/en got %b expected 00000", {busy, en_vec});
        end
        bin_val = 1'b0;
    endtask

    task automatic test_async_reset();
        bin_val = 1'b0;
        tick();
        bin_val = 1'b1;
        tick();
        pulse_done(0);
        pulse_done(1);
        tick();
        #3;
        rst_n   = 1'b0;
        bin_val = 1'b0;
        #1;
        vectors++;
        if ({busy, en_vec, frame_done, err} !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL areset_immediate: busy/en/fd/err got %b expected 0000000", {busy, en_vec, frame_done, err});
        end
        vectors++;
        if ({frame_cnt, ib_vec} !== 15'd0) begin
            miscompares++;
            $display("[TB] FAIL areset_cnt_port: cnt %0d ib %h expected 0 0", frame_cnt, ib_vec);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({frame_done, busy} !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL areset_hold[%0d]: fd/busy got %b expected 00", i, {frame_done, busy});
            end
        end
        rst_n = 1'b1;
        exp_frames = 8'd0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL areset_no_spurious_start: busy got %b expected 0", busy);
        end
        bin_val = 1'b1;
        tick();
        vectors++;
        if ({busy, en_vec, frame_cnt} !== {1'b1, 4'b1000, 8'd0}) begin
            miscompares++;
            $display("[TB] FAIL areset_restart: busy/en/cnt got %b expected %b", {busy, en_vec, frame_cnt}, {1'b1, 4'b1000, 8'd0});
        end
        pulse_done(0);
        pulse_done(1);
        pulse_done(2);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        exp_frames = exp_frames + 8'd1;
        vectors++;
        if ({frame_done, frame_cnt} !== {1'b1, exp_frames}) begin
            miscompares++;
            $display("[TB] FAIL areset_clean_frame: fd %b cnt %0d expected 1 %0d", frame_done, frame_cnt, exp_frames);
        end
        tick();
        bin_val = 1'b0;
    endtask

    // Run every scenario in order, then report
    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_frames  = 8'd0;
        test_reset();
        test_stray_dones();
        test_nominal();
        test_watchdog();
        test_timeout_tie();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
